// File: rtl/reg_scoreboard_if.sv
// Read/WB-stage handshake and status bundle between the pipeline and the register scoreboard.
interface reg_scoreboard_if;
  logic       issue_valid;
  logic       issue_ready;
  logic       issue_use_src1;
  logic [2:0] issue_src1;
  logic       issue_use_src2;
  logic [2:0] issue_src2;
  logic       issue_has_dest;
  logic [2:0] issue_dest;
  logic       wb_valid;
  logic [2:0] wb_dest;
  logic       flush;
  logic [7:0] busy_mask;
  logic [3:0] inflight;
  logic       wb_err;

  modport master (
    output issue_valid, issue_use_src1, issue_src1, issue_use_src2, issue_src2,
           issue_has_dest, issue_dest, wb_valid, wb_dest, flush,
    input  issue_ready, busy_mask, inflight, wb_err
  );

  modport slave (
    input  issue_valid, issue_use_src1, issue_src1, issue_use_src2, issue_src2,
           issue_has_dest, issue_dest, wb_valid, wb_dest, flush,
    output issue_ready, busy_mask, inflight, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters gating issue from Read,
// released by WB commits, with flush, in-flight bound and sticky WB error.
module reg_scoreboard #(
  parameter int unsigned PEND_BITS    = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  localparam int unsigned NREGS = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef logic [PEND_BITS-1:0] pend_t;

  localparam pend_t             PEND_MAX = '1;
  localparam logic [CNT_W-1:0]  INFL_MAX = CNT_W'(MAX_INFLIGHT);

  pend_t [NREGS-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [NREGS-1:0]   busy_q, busy_d;
  logic               wb_err_q, wb_err_d;
  logic               ready_c, inc_c, dec_c, wb_bad_c;

  // Issue gate: a same-cycle WB does not clear a source hazard (pend_q is pre-edge).
  always_comb begin
    ready_c = rst & ~sb.flush;
    if (sb.issue_use_src1 && (pend_q[sb.issue_src1] != '0)) ready_c = 1'b0;
    if (sb.issue_use_src2 && (pend_q[sb.issue_src2] != '0)) ready_c = 1'b0;
    if (sb.issue_has_dest && (pend_q[sb.issue_dest] == PEND_MAX)) ready_c = 1'b0;
    if (sb.issue_has_dest && (inflight_q == INFL_MAX)) ready_c = 1'b0;
  end

  always_comb begin
    inc_c      = sb.issue_valid & ready_c & sb.issue_has_dest;
    dec_c      = sb.wb_valid & (pend_q[sb.wb_dest] != '0);
    wb_bad_c   = sb.wb_valid & (pend_q[sb.wb_dest] == '0);
    pend_d     = pend_q;
    inflight_d = inflight_q + CNT_W'(inc_c) - CNT_W'(dec_c);
    wb_err_d   = wb_err_q | wb_bad_c;
    busy_d     = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (inc_c && (sb.issue_dest == IDX_W'(i))) pend_d[i] = pend_d[i] + PEND_BITS'(1);
      if (dec_c && (sb.wb_dest == IDX_W'(i)))    pend_d[i] = pend_d[i] - PEND_BITS'(1);
    end
    // Flush drops every outstanding write but leaves the error flag alone.
    if (sb.flush) begin
      pend_d     = '0;
      inflight_d = '0;
    end
    for (int i = 0; i < NREGS; i++) busy_d[i] = (pend_d[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q     <= '0;
      inflight_q <= '0;
      busy_q     <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign sb.issue_ready = ready_c;
  assign sb.busy_mask   = busy_q;
  assign sb.inflight    = inflight_q;
  assign sb.wb_err      = wb_err_q;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard controller sequencing the 8-entry register file between the Read and WB pipeline stages.
- Tracks outstanding writes per architectural register and decides whether the instruction in Read may issue.
- Blocks issue until all source operands are committed, and bounds the number of in-flight writes.
- Also provides pipeline flush support and debug/status outputs.

Parameters:
PEND_BITS, 2, width of each per-register pending-write counter (max pending per reg = 2**PEND_BITS-1 = 3)
MAX_INFLIGHT, 4, maximum total outstanding writes across all registers (1..8)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
issue_valid  input  1  Read stage presents an instruction
issue_ready  output  1  scoreboard accepts it; issue occurs when issue_valid && issue_ready
issue_use_src1  input  1  instruction reads src1
issue_src1  input  3  source register 1
issue_use_src2  input  1  instruction reads src2
issue_src2  input  3  source register 2
issue_has_dest  input  1  instruction will write a register
issue_dest  input  3  destination register
wb_valid  input  1  WB stage commits a result this cycle
wb_dest  input  3  register being written by WB
flush  input  1  discard all in-flight instructions
busy_mask  output  8  bit i = 1 when pend[i] != 0 (registered view of counters)
inflight  output  4  total outstanding writes
wb_err  output  1  sticky; a WB occurred to a register with pend == 0

Behaviour:
- State: pend[0..7] (PEND_BITS each), inflight counter, wb_err flag. All registered on posedge clk.
- Reset (rst == 0 at posedge):
  - all pend = 0, inflight = 0, wb_err = 0.
  - issue_ready is held 0 combinationally while rst == 0.
  - busy_mask = 0 and inflight = 0 from the first edge after reset.
- issue_ready is combinational and equals 1 only when all of the following hold:
  - rst == 1 and flush == 0;
  - !(issue_use_src1 && pend[issue_src1] != 0);
  - !(issue_use_src2 && pend[issue_src2] != 0);
  - !(issue_has_dest && pend[issue_dest] == max);
  - !(issue_has_dest && inflight == MAX_INFLIGHT).
- issue_ready does not depend on issue_valid. A same-cycle WB does not unblock a source hazard: the register file writes at the edge, so the dependent instruction issues on the following cycle, one-cycle bubble minimum.
- Counter updates at each edge:
  - inc = issue_valid && issue_ready && issue_has_dest; dec = wb_valid && pend[wb_dest] != 0.
  - pend[issue_dest] += inc; pend[wb_dest] -= dec.
  - Same register with inc and dec together: no change.
  - inflight += inc - dec, saturating at neither end because the ready conditions guarantee no overflow.
- WB with pend[wb_dest] == 0: no counter change, wb_err set to 1. It stays set until reset.
- Flush:
  - when flush == 1 at an edge, all pend and inflight clear to 0, overriding any same-cycle issue or WB;
  - wb_err is unaffected;
  - issue_ready = 0 during the flush cycle.
- Reset mid-operation discards all state identically to power-on reset.
- Issue latency: 0 cycles (combinational ready). State update latency: 1 cycle.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with issue_valid = 1 -> issue_ready = 0; after release, busy_mask = 8'h00, inflight = 0, wb_err = 0.
- RAW stall: issue dest = 3 (ready = 1) -> next cycle busy_mask = 8'h08; issue src1 = 3 -> ready = 0; WB dest = 3 at cycle N -> ready still 0 in N, = 1 in N+1, busy_mask = 0.
- Multiple pending: issue dest = 5 three times -> pend[5] = 3, fourth issue dest = 5 -> ready = 0; one WB to 5 -> ready = 1 next cycle.
- In-flight limit: issue dests 0,1,2,3 -> inflight = 4, issue dest = 4 with no sources -> ready = 0; an instruction with issue_has_dest = 0 and free sources -> ready = 1.
- Simultaneous: pend[2] = 1, issue dest = 2 and WB dest = 2 same cycle -> pend[2] stays 1, inflight unchanged.
- Flush/error: 3 in-flight writes, flush = 1 with concurrent issue -> ready = 0, next cycle inflight = 0, busy_mask = 0; then WB dest = 6 -> wb_err = 1, sticky until rst.
